// File: rtl/sel_campo_ajuste_pkg.sv
// Shared types for the adjust-mode field selector: mode encoding and per-mode field count.
// Pure declarations, no logic or timing of its own.
// Used by sel_campo_ajuste; field counts are supplied by the caller's parameters.
package ajuste_pkg;

  typedef enum logic [1:0] {
    MODO_IDLE  = 2'd0,
    MODO_HORA  = 2'd1,
    MODO_FECHA = 2'd2,
    MODO_CRONO = 2'd3
  } modo_t;

  // Number of adjustable fields for a mode; IDLE reports 1 so index math stays in range.
  function automatic int n_campos(input modo_t m, input int n_hora, input int n_fecha,
                                  input int n_crono);
    case (m)
      MODO_HORA:  return n_hora;
      MODO_FECHA: return n_fecha;
      MODO_CRONO: return n_crono;
      default:    return 1;
    endcase
  endfunction

endpackage

// File: rtl/sel_campo_ajuste_detector_flanco.sv
// Rising-edge detector for a debounced level input.
// Pulse is combinational from the input against a one-cycle-old copy.
// The history flop has no reset, so a level held through reset never produces a pulse.
module detector_flanco (
  input  logic clk,
  input  logic in,
  output logic out
);

  logic prev_q;
  logic prev_d;

  // History copy of the input, captured every cycle regardless of reset.
  always_comb begin
    prev_d = in;
  end

  // Previous-level register.
  always_ff @(posedge clk) begin
    prev_q <= prev_d;
  end

  assign out = in & ~prev_q;

endmodule

// File: rtl/sel_campo_ajuste.sv
// Adjust-mode field selector: decodes mode switches, walks a wrapping field index, blinks it.
// All outputs registered; a button edge or switch change shows on the edge that samples it.
// No backpressure: button edges on a mode-change cycle or in IDLE are dropped.
module sel_campo_ajuste
  import ajuste_pkg::*;
#(
  parameter int N_HORA    = 3,
  parameter int N_FECHA   = 3,
  parameter int N_CRONO   = 3,
  parameter int MAX_N     = 4,
  parameter int IDX_W     = 2,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sw_hora,
  input  logic             sw_fecha,
  input  logic             sw_cronometro,
  input  logic             parametro_der,
  input  logic             parametro_izq,
  output logic [1:0]       modo,
  output logic             ajuste_activo,
  output logic [IDX_W-1:0] campo_sel,
  output logic [MAX_N-1:0] campo_onehot,
  output logic             parpadeo
);

  localparam int CNT_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);

  logic der_e;
  logic izq_e;

  modo_t            modo_q, modo_d, modo_sw;
  logic [IDX_W-1:0] idx_q, idx_d, last_idx;
  logic [MAX_N-1:0] onehot_q, onehot_d;
  logic             activo_q, activo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             parp_q, parp_d;
  logic             cambio_modo;

  detector_flanco u_flanco_der (
    .clk (clk),
    .in  (parametro_der),
    .out (der_e)
  );

  detector_flanco u_flanco_izq (
    .clk (clk),
    .in  (parametro_izq),
    .out (izq_e)
  );

  // Mode decode and field-index walk; onehot is derived from the next index so it never lags.
  always_comb begin
    modo_sw = MODO_IDLE;
    case ({sw_hora, sw_fecha, sw_cronometro})
      3'b100:  modo_sw = MODO_HORA;
      3'b010:  modo_sw = MODO_FECHA;
      3'b001:  modo_sw = MODO_CRONO;
      default: modo_sw = MODO_IDLE;
    endcase

    last_idx    = IDX_W'(n_campos(modo_q, N_HORA, N_FECHA, N_CRONO) - 1);
    cambio_modo = (modo_sw != modo_q);
    modo_d      = modo_sw;
    idx_d       = idx_q;

    if (cambio_modo || (modo_q == MODO_IDLE)) begin
      idx_d = '0;
    end else if (der_e && !izq_e) begin
      idx_d = (idx_q == last_idx) ? '0 : idx_q + 1'b1;
    end else if (izq_e && !der_e) begin
      idx_d = (idx_q == '0) ? last_idx : idx_q - 1'b1;
    end

    activo_d = (modo_d != MODO_IDLE);
    onehot_d = activo_d ? (MAX_N'(1) << idx_d) : '0;
  end

  // Mode / index / one-hot state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      modo_q   <= MODO_IDLE;
      idx_q    <= '0;
      onehot_q <= '0;
      activo_q <= 1'b0;
    end else begin
      modo_q   <= modo_d;
      idx_q    <= idx_d;
      onehot_q <= onehot_d;
      activo_q <= activo_d;
    end
  end

  // Blink timing: a move or entering a mode restarts the period with the field visible.
  always_comb begin
    cnt_d  = cnt_q;
    parp_d = parp_q;
    if (modo_d == MODO_IDLE) begin
      cnt_d  = '0;
      parp_d = 1'b0;
    end else if (cambio_modo || (idx_d != idx_q)) begin
      cnt_d  = '0;
      parp_d = 1'b1;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d  = '0;
      parp_d = ~parp_q;
    end else begin
      cnt_d  = cnt_q + 1'b1;
    end
  end

  // Blink counter and phase register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      parp_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      parp_q <= parp_d;
    end
  end

  assign modo          = modo_q;
  assign ajuste_activo = activo_q;
  assign campo_sel     = idx_q;
  assign campo_onehot  = onehot_q;
  assign parpadeo      = parp_q;

endmodule
